// File: rtl/axi_lcd_tou_regbank.sv
// AXI4-Lite register bank for the LCD/touch subsystem: byte-strobed general registers, RO status slots, write pulses.
// Defining LCD_REGBANK_IRQ_EN adds IRQ_STAT/IRQ_EN after the general registers and drives irq from touch_evt.
module axi_lcd_tou_regbank #(
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
    input  logic                       S_AXI_AWVALID,
    output logic                       S_AXI_AWREADY,
    input  logic [DATA_W-1:0]          S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
    input  logic                       S_AXI_WVALID,
    output logic                       S_AXI_WREADY,
    output logic [1:0]                 S_AXI_BRESP,
    output logic                       S_AXI_BVALID,
    input  logic                       S_AXI_BREADY,
    input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
    input  logic                       S_AXI_ARVALID,
    output logic                       S_AXI_ARREADY,
    output logic [DATA_W-1:0]          S_AXI_RDATA,
    output logic [1:0]                 S_AXI_RRESP,
    output logic                       S_AXI_RVALID,
    input  logic                       S_AXI_RREADY,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    input  logic [NUM_REGS*DATA_W-1:0] reg_in,
    output logic [NUM_REGS-1:0]        wr_pulse,
    input  logic                       touch_evt,
    output logic                       irq
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB = $clog2(STRB_W);
    localparam int IDX_W = ADDR_W - LSB;
`ifdef LCD_REGBANK_IRQ_EN
    localparam int NUM_WORDS = NUM_REGS + 2;
`else
    localparam int NUM_WORDS = NUM_REGS;
`endif
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                ready_en_reg;
    logic                aw_full_reg, w_full_reg;
    logic [ADDR_W-1:0]   aw_addr_reg;
    logic [DATA_W-1:0]   w_data_reg;
    logic [STRB_W-1:0]   w_strb_reg;
    logic                bvalid_reg, rvalid_reg;
    logic [1:0]          bresp_reg, rresp_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [NUM_REGS-1:0] wr_pulse_reg;
    logic [NUM_REGS-1:0] wr_hit;
    logic [DATA_W-1:0]   rd_tap [NUM_REGS];

    logic                aw_hs, w_hs, ar_hs, wr_fire, wr_in_range;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [STRB_W-1:0]   wr_strb;
    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic [DATA_W-1:0]   rd_data_next;
    logic                rd_err_next;

    assign S_AXI_AWREADY = ready_en_reg & ~aw_full_reg;
    assign S_AXI_WREADY  = ready_en_reg & ~w_full_reg;
    assign S_AXI_ARREADY = ready_en_reg & ~rvalid_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign wr_pulse      = wr_pulse_reg;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // A channel arriving this cycle counts as a filled slot, so the write fires in its handshake cycle.
    assign wr_addr = aw_full_reg ? aw_addr_reg : S_AXI_AWADDR;
    assign wr_data = w_full_reg ? w_data_reg : S_AXI_WDATA;
    assign wr_strb = w_full_reg ? w_strb_reg : S_AXI_WSTRB;
    assign wr_fire = (aw_full_reg | aw_hs) & (w_full_reg | w_hs) & ~bvalid_reg;
    assign wr_idx  = wr_addr[ADDR_W-1:LSB];
    assign rd_idx  = S_AXI_ARADDR[ADDR_W-1:LSB];
    assign wr_in_range = ({1'b0, wr_idx} < (IDX_W+1)'(NUM_WORDS));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ready_en_reg <= 1'b0;
            aw_full_reg  <= 1'b0;
            w_full_reg   <= 1'b0;
            aw_addr_reg  <= '0;
            w_data_reg   <= '0;
            w_strb_reg   <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
            wr_pulse_reg <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            wr_pulse_reg <= wr_hit;
            if (bvalid_reg && S_AXI_BREADY) begin
                aw_full_reg <= 1'b0;
                w_full_reg  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_full_reg <= 1'b1;
                    aw_addr_reg <= S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_full_reg <= 1'b1;
                    w_data_reg <= S_AXI_WDATA;
                    w_strb_reg <= S_AXI_WSTRB;
                end
            end
            if (wr_fire) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_reg && S_AXI_BREADY) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
            logic [DATA_W-1:0] r_reg;
            assign wr_hit[gi] = wr_fire && (wr_idx == IDX_W'(gi)) && !RO_MASK[gi];
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    r_reg <= '0;
                end else if (wr_hit[gi]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) r_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
            assign reg_out[gi*DATA_W +: DATA_W] = r_reg;
            assign rd_tap[gi] = RO_MASK[gi] ? reg_in[gi*DATA_W +: DATA_W] : r_reg;
        end
    endgenerate

`ifdef LCD_REGBANK_IRQ_EN
    logic irq_stat_reg, irq_en_reg, irq_reg;
    logic stat_w1c, en_wr;
    assign stat_w1c = wr_fire && (wr_idx == IDX_W'(NUM_REGS)) && wr_strb[0] && wr_data[0];
    assign en_wr    = wr_fire && (wr_idx == IDX_W'(NUM_REGS + 1)) && wr_strb[0];
    assign irq      = irq_reg;

    // A touch event in the same cycle as a clear keeps the status set.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            irq_stat_reg <= 1'b0;
            irq_en_reg   <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            if (touch_evt)     irq_stat_reg <= 1'b1;
            else if (stat_w1c) irq_stat_reg <= 1'b0;
            if (en_wr)         irq_en_reg <= wr_data[0];
            irq_reg <= irq_stat_reg & irq_en_reg;
        end
    end
`else
    assign irq = 1'b0;
    logic unused_irq;
    assign unused_irq = &{1'b0, touch_evt};
`endif

    logic unused_addr;
    assign unused_addr = &{1'b0, wr_addr[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

    always_comb begin
        rd_data_next = '0;
        rd_err_next  = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data_next = rd_tap[i];
                rd_err_next  = 1'b0;
            end
        end
`ifdef LCD_REGBANK_IRQ_EN
        if (rd_idx == IDX_W'(NUM_REGS)) begin
            rd_data_next = DATA_W'(irq_stat_reg);
            rd_err_next  = 1'b0;
        end
        if (rd_idx == IDX_W'(NUM_REGS + 1)) begin
            rd_data_next = DATA_W'(irq_en_reg);
            rd_err_next  = 1'b0;
        end
`endif
    end

    // Captured on the AR handshake edge, so a coincident write is seen with its old value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_reg <= 1'b0;
            rresp_reg  <= RESP_OKAY;
            rdata_reg  <= '0;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data_next;
            rresp_reg  <= rd_err_next ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_reg && S_AXI_RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_lcd_tou_regbank.sv
// Directed testbench for axi_lcd_tou_regbank (DATA_W=32, NUM_REGS=8, RO_MASK=8'h01).
module tb_axi_lcd_tou_regbank;
    logic         ACLK = 1'b0;
    logic         ARESET = 1'b0;
    logic [7:0]   S_AXI_AWADDR = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b0;
    logic [7:0]   S_AXI_ARADDR = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b0;
    logic [255:0] reg_out;
    logic [255:0] reg_in;
    logic [7:0]   wr_pulse;
    logic         touch_evt = 1'b0;
    logic         irq;

    int n_checks = 0;
    int n_pass = 0;
    int pulse_cnt [8] = '{default: 0};

    assign reg_in = {{7{32'hDEADBEEF}}, 32'hCAFE0001};

    axi_lcd_tou_regbank #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(8), .RO_MASK(8'h01)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse), .touch_evt(touch_evt), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        for (int i = 0; i < 8; i++) if (wr_pulse[i]) pulse_cnt[i]++;
    end

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_go, w_go, b_go, done;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1; done = 1'b0; resp = 2'bxx;
        for (int n = 0; n < 20 && !done; n++) begin
            aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
            w_go = S_AXI_WVALID && S_AXI_WREADY;
            b_go = S_AXI_BVALID && S_AXI_BREADY;
            if (b_go) resp = S_AXI_BRESP;
            @(posedge ACLK); #1;
            if (aw_go) S_AXI_AWVALID = 1'b0;
            if (w_go) S_AXI_WVALID = 1'b0;
            if (b_go) done = 1'b1;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL write_timeout addr=%h got no B response within 20 cycles", addr);
        end
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ar_go, r_go, done;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        done = 1'b0; data = 'x; resp = 2'bxx;
        for (int n = 0; n < 20 && !done; n++) begin
            ar_go = S_AXI_ARVALID && S_AXI_ARREADY;
            r_go = S_AXI_RVALID && S_AXI_RREADY;
            if (r_go) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; end
            @(posedge ACLK); #1;
            if (ar_go) S_AXI_ARVALID = 1'b0;
            if (r_go) done = 1'b1;
        end
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL read_timeout addr=%h got no R response within 20 cycles", addr);
        end
    endtask

    task automatic test_reset();
        #2 ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        n_checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000)
            $display("FAIL reset_ready got %b exp 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        else n_pass++;
        n_checks++;
        if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, irq} !== 7'b0)
            $display("FAIL reset_resp got %b exp 0",
                     {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, irq});
        else n_pass++;
        n_checks++;
        if (reg_out !== '0 || wr_pulse !== '0 || S_AXI_RDATA !== '0)
            $display("FAIL reset_regs got reg_out=%h wr_pulse=%h rdata=%h exp 0", reg_out, wr_pulse, S_AXI_RDATA);
        else n_pass++;
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        n_checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111)
            $display("FAIL release_ready got %b exp 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        else n_pass++;
    endtask

    task automatic test_sequential();
        logic [1:0] resp;
        logic [31:0] data, exp;
        int base [8];
        for (int i = 0; i < 8; i++) base[i] = pulse_cnt[i];
        for (int i = 0; i < 8; i++) begin
            axi_write(8'(i * 4), 32'(i + 1), 4'hF, resp);
            n_checks++;
            if (resp !== 2'b00) $display("FAIL seq_bresp reg=%0d got %b exp 00", i, resp);
            else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            axi_read(8'(i * 4), data, resp);
            exp = (i == 0) ? 32'hCAFE0001 : 32'(i + 1);
            n_checks++;
            if (data !== exp || resp !== 2'b00)
                $display("FAIL seq_read reg=%0d got %h/%b exp %h/00", i, data, resp, exp);
            else n_pass++;
            exp = (i == 0) ? 32'h0 : 32'(i + 1);
            n_checks++;
            if (reg_out[i*32 +: 32] !== exp)
                $display("FAIL seq_reg_out reg=%0d got %h exp %h", i, reg_out[i*32 +: 32], exp);
            else n_pass++;
            n_checks++;
            if (pulse_cnt[i] - base[i] !== ((i == 0) ? 0 : 1))
                $display("FAIL seq_pulse reg=%0d got %0d exp %0d", i, pulse_cnt[i] - base[i], (i == 0) ? 0 : 1);
            else n_pass++;
        end
    endtask

    task automatic test_byte_strobe();
        logic [1:0] resp;
        logic [31:0] data;
        axi_write(8'h08, 32'hFFFFFFFF, 4'hF, resp);
        axi_write(8'h08, 32'h12345678, 4'b0101, resp);
        axi_read(8'h08, data, resp);
        n_checks++;
        if (data !== 32'hFF34FF78 || resp !== 2'b00)
            $display("FAIL byte_strobe got %h/%b exp ff34ff78/00", data, resp);
        else n_pass++;
    endtask

    task automatic test_ro_and_range();
        logic [1:0] resp, exp_resp;
        logic [31:0] data;
        int base0;
        base0 = pulse_cnt[0];
        axi_write(8'h00, 32'h11112222, 4'hF, resp);
        n_checks++;
        if (resp !== 2'b00) $display("FAIL ro_bresp got %b exp 00", resp);
        else n_pass++;
        n_checks++;
        if (reg_out[31:0] !== 32'h0 || pulse_cnt[0] !== base0)
            $display("FAIL ro_no_write got reg_out0=%h pulses=%0d exp 0/%0d", reg_out[31:0], pulse_cnt[0], base0);
        else n_pass++;
        axi_read(8'h00, data, resp);
        n_checks++;
        if (data !== 32'hCAFE0001) $display("FAIL ro_read got %h exp cafe0001", data);
        else n_pass++;
        axi_read(8'h40, data, resp);
        n_checks++;
        if (data !== 32'h0 || resp !== 2'b10) $display("FAIL oor_read got %h/%b exp 0/10", data, resp);
        else n_pass++;
`ifdef LCD_REGBANK_IRQ_EN
        exp_resp = 2'b00;
`else
        exp_resp = 2'b10;
`endif
        axi_read(8'h20, data, resp);
        n_checks++;
        if (data !== 32'h0 || resp !== exp_resp)
            $display("FAIL irq_slot_read got %h/%b exp 0/%b", data, resp, exp_resp);
        else n_pass++;
        axi_write(8'h24, 32'h0, 4'hF, resp);
        n_checks++;
        if (resp !== exp_resp) $display("FAIL irq_slot_write got %b exp %b", resp, exp_resp);
        else n_pass++;
    endtask

    task automatic test_channel_skew();
        int base5;
        base5 = pulse_cnt[5];
        S_AXI_WDATA = 32'hA5A50005; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        n_checks++;
        if (S_AXI_WREADY !== 1'b0 || S_AXI_AWREADY !== 1'b1)
            $display("FAIL skew_slots got wready=%b awready=%b exp 0/1", S_AXI_WREADY, S_AXI_AWREADY);
        else n_pass++;
        repeat (4) begin @(posedge ACLK); #1; end
        n_checks++;
        if (S_AXI_BVALID !== 1'b0) $display("FAIL skew_early_b got %b exp 0", S_AXI_BVALID);
        else n_pass++;
        S_AXI_AWADDR = 8'h14; S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        n_checks++;
        if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00)
            $display("FAIL skew_b_latency got %b/%b exp 1/00", S_AXI_BVALID, S_AXI_BRESP);
        else n_pass++;
        for (int n = 0; n < 3; n++) begin
            @(posedge ACLK); #1;
            n_checks++;
            if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00)
                $display("FAIL skew_b_hold cycle=%0d got %b/%b exp 1/00", n, S_AXI_BVALID, S_AXI_BRESP);
            else n_pass++;
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        n_checks++;
        if (S_AXI_BVALID !== 1'b0) $display("FAIL skew_b_release got %b exp 0", S_AXI_BVALID);
        else n_pass++;
        n_checks++;
        if (reg_out[5*32 +: 32] !== 32'hA5A50005 || pulse_cnt[5] - base5 !== 1)
            $display("FAIL skew_commit got %h pulses=%0d exp a5a50005/1", reg_out[5*32 +: 32], pulse_cnt[5] - base5);
        else n_pass++;
    endtask

`ifdef LCD_REGBANK_IRQ_EN
    task automatic test_irq();
        logic [1:0] resp;
        logic [31:0] data;
        axi_write(8'h24, 32'h1, 4'hF, resp);
        touch_evt = 1'b1;
        @(posedge ACLK); #1;
        touch_evt = 1'b0;
        for (int n = 0; n < 3 && !irq; n++) begin @(posedge ACLK); #1; end
        n_checks++;
        if (irq !== 1'b1) $display("FAIL irq_set got %b exp 1", irq);
        else n_pass++;
        S_AXI_AWADDR = 8'h20; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1; touch_evt = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; touch_evt = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        repeat (2) begin @(posedge ACLK); #1; end
        n_checks++;
        if (irq !== 1'b1) $display("FAIL irq_set_wins got %b exp 1", irq);
        else n_pass++;
        axi_read(8'h20, data, resp);
        n_checks++;
        if (data !== 32'h1) $display("FAIL irq_stat_read got %h exp 1", data);
        else n_pass++;
        axi_write(8'h20, 32'h1, 4'hF, resp);
        repeat (2) begin @(posedge ACLK); #1; end
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_clear got %b exp 0", irq);
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_write();
        bit saw_b;
        S_AXI_AWADDR = 8'h18; S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        n_checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000)
            $display("FAIL midrst_ready_low got %b exp 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        else n_pass++;
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        n_checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111)
            $display("FAIL midrst_ready_back got %b exp 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        else n_pass++;
        S_AXI_WDATA = 32'h77777777; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        saw_b = 1'b0;
        repeat (3) begin
            if (S_AXI_BVALID) saw_b = 1'b1;
            @(posedge ACLK); #1;
        end
        S_AXI_BREADY = 1'b0;
        n_checks++;
        if (saw_b !== 1'b0) $display("FAIL midrst_no_b got bvalid=1 exp 0");
        else n_pass++;
        n_checks++;
        if (reg_out !== '0) $display("FAIL midrst_regs got %h exp 0", reg_out);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_byte_strobe();
        test_ro_and_range();
        test_channel_skew();
`ifdef LCD_REGBANK_IRQ_EN
        test_irq();
`endif
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_lcd_tou_regbank.md
# axi_lcd_tou_regbank

Parametrised AXI4-Lite slave register bank for the LCD/touch driver subsystem. It generalises the fixed four-register slave to a configurable register count and data width, with byte strobes, per-register read-only status slots fed from the touch controller, and per-register write pulses to the LCD engine. It adds a sticky, maskable touch-event interrupt. It sits between the AXI interconnect and the LCD timing and touch-scan logic.

## Interface
- DATA_W, 32: AXI data width; 32 or 64.
- NUM_REGS, 8: number of general registers; 4..64.
- ADDR_W, 8: AXI address width; must cover NUM_REGS+2 words.
- RO_MASK, 'h0: NUM_REGS bits. Bit i=1 makes register i read-only; reads return the reg_in slice i.

- ACLK  in  1  clock.
- ARESET  in  1  asynchronous reset, active-high.
- S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  ADDR_W/1/1  write address channel.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  ADDR_W/1/1  read address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_W/2/1/1  read data channel.
- reg_out  out  NUM_REGS*DATA_W  flattened writable register contents; slice i = register i.
- reg_in  in  NUM_REGS*DATA_W  flattened status inputs for RO slots.
- wr_pulse  out  NUM_REGS  one-cycle strobe per successful write to register i.
- touch_evt  in  1  single-cycle touch event pulse.
- irq  out  1  level interrupt.

## Operation
- Word index is the address bits [ADDR_W-1 : log2(DATA_W/8)]. Low address bits are ignored.
- Write path: AW and W are latched independently. Each READY is high while its holding slot is empty. When both slots are full, a write fires in that cycle.
- On write fire, each byte with WSTRB set is updated. BVALID asserts on the next cycle. Both slots are freed on the B handshake. Only one write is outstanding.
- Write responses:
  - Write to an RO register: BRESP=OKAY; data ignored; no wr_pulse.
  - Index ≥ NUM_REGS with no IRQ register present: BRESP=SLVERR (2'b10); no state change.
  - Otherwise: BRESP=OKAY; wr_pulse[i] is high for the fire cycle+1 only.
- Read path: ARREADY is high when no read is pending. On the AR handshake, RDATA/RRESP are registered and RVALID rises on the next cycle. RVALID holds until RREADY. Only one read is outstanding.
- Read responses:
  - Out-of-range index: RDATA=0, RRESP=SLVERR.
- Read and write in the same cycle to the same register: the read captures the pre-write value.
- Reset values:
  - All registers are 0. reg_out=0, wr_pulse=0, irq=0.
  - All READY signals are 0 while ARESET is high, then 1 from the first clock after release.
  - BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0.
- Reset asserted mid-transaction discards latched AW/W/AR and pending responses immediately.

## Timing
- Write latency: BVALID = max(AW handshake, W handshake) + 1 cycle. Back-to-back writes sustain one write per 2 cycles with BREADY held high.
- Read latency: RVALID = AR handshake + 1 cycle. Sustained rate is one read per 2 cycles.
- VALID outputs never drop without the matching READY. RDATA/BRESP are stable while VALID is high.
- reg_out updates on the edge after write fire, in the same cycle as wr_pulse and BVALID.

## Configuration
- LCD_REGBANK_IRQ_EN defined:
  - Index NUM_REGS is IRQ_STAT. Bit0 is sticky: set by touch_evt, cleared by writing 1 to bit0 (W1C).
  - Index NUM_REGS+1 is IRQ_EN, bit0 read/write.
  - Other bits of both registers read 0.
  - irq = IRQ_STAT[0] & IRQ_EN[0], registered, one cycle after the state change.
  - touch_evt and a W1C in the same cycle: set wins.
- LCD_REGBANK_IRQ_EN undefined:
  - Both indices return SLVERR.
  - irq is tied 0 and touch_evt is ignored.
  - Ports are unchanged.

## Test plan
- Sequential write then readback: DATA_W=32, NUM_REGS=8. Write 0x1..0x8 to addrs 0x00..0x1C, read back -> each RDATA matches, all RESP=OKAY, wr_pulse[i] fires once per write.
- Byte strobes: write 0xFFFFFFFF to reg 2, then 0x12345678 with WSTRB=4'b0101 -> read 0xFF34FF78.
- RO slot and out-of-range: RO_MASK=8'h01, reg_in slice0=0xCAFE0001. Write reg0 -> OKAY, read returns 0xCAFE0001, no wr_pulse. Read addr 0x40 with IRQ disabled -> RRESP=SLVERR, RDATA=0.
- Channel skew: W presented 5 cycles before AW, BREADY low for 3 cycles -> BVALID 1 cycle after AW handshake, held stable until BREADY, value committed once.
- IRQ (macro on): IRQ_EN=1, pulse touch_evt -> irq=1 next cycle. W1C to IRQ_STAT coincident with touch_evt -> irq stays 1. Plain W1C -> irq=0.
- Reset mid-write: AW latched, ARESET pulsed before W -> no BVALID after release, registers 0, READY signals return to 1.
